// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals of the unified memory arbiter.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic            dm_req;
    logic            dm_we;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic [DW/8-1:0] dm_be;
    logic [DW-1:0]   dm_rdata;
    logic            dm_ack;
    logic stall_if;
    logic stall_mem;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ready;

    modport slave (
        input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
               mem_rdata, mem_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack, stall_if, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
               mem_rdata, mem_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack, stall_if, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data stages, DM-priority with a streak limit.
module mem_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_DM_STREAK + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DONE} state_t;

    state_t          state_q, state_d;
    logic            side_dm_q, side_dm_d;
    logic            cancel_q, cancel_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW/8-1:0] mem_be_q, mem_be_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
    logic            grant_if, grant_dm, streak_max;

    assign streak_max = streak_q == SW'(MAX_DM_STREAK);

    always_comb begin
        state_d     = state_q;
        side_dm_d   = side_dm_q;
        streak_d    = streak_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        grant_if    = 1'b0;
        grant_dm    = 1'b0;
        // A flush cancels the fetch that is in flight or waiting for its ack slot.
        cancel_d = (state_q == IDLE) ? 1'b0 :
                   cancel_q | (bus.if_flush & (state_q == BUSY_IF | (state_q == DONE & ~side_dm_q)));
        case (state_q)
            IDLE: begin
                grant_if = bus.if_req & ~bus.if_flush & (~bus.dm_req | streak_max);
                grant_dm = bus.dm_req & ~grant_if;
                if (grant_if) begin
                    state_d     = BUSY_IF;
                    side_dm_d   = 1'b0;
                    streak_d    = '0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '0;
                end else if (grant_dm) begin
                    state_d     = BUSY_DM;
                    side_dm_d   = 1'b1;
                    streak_d    = ~bus.if_req ? '0 : streak_max ? streak_q : streak_q + SW'(1);
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    mem_be_d    = bus.dm_be;
                end
            end
            BUSY_IF: begin
                state_d    = bus.mem_ready ? DONE : BUSY_IF;
                if_rdata_d = (bus.mem_ready & ~cancel_d) ? bus.mem_rdata : if_rdata_q;
            end
            BUSY_DM: begin
                state_d    = bus.mem_ready ? DONE : BUSY_DM;
                dm_rdata_d = bus.mem_ready ? bus.mem_rdata : dm_rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            side_dm_q   <= 1'b0;
            cancel_q    <= 1'b0;
            streak_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            side_dm_q   <= side_dm_d;
            cancel_q    <= cancel_d;
            streak_q    <= streak_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign bus.mem_req   = state_q == BUSY_IF | state_q == BUSY_DM;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = state_q == DONE & ~side_dm_q & ~cancel_q & ~bus.if_flush;
    assign bus.dm_ack    = state_q == DONE & side_dm_q;
    assign bus.stall_if  = bus.if_req & ~bus.if_ack;
    assign bus.stall_mem = bus.dm_req & ~bus.dm_ack;
endmodule
